gigatron_xio: RTL and testbench

- Parametrised extended-I/O unit, successor to the CPU-embedded xout/in latch logic.
- Detects a configurable edge on a chosen bit of the CPU output register (hsync by default).
- On that edge it latches the accumulator into the extended output and publishes the last controller word.
- It also runs its own serial game-controller scan (latch/clock/data, Famicom-style). The CPU core instantiates it between reg_out/reg_acc and the board pins.

---
 rtl/gigatron_xio_if.sv | 28 ++
 rtl/gigatron_xio.sv | 145 ++++++++++++++
 tb/tb_gigatron_xio.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/gigatron_xio_if.sv
// gigatron_xio_if: CPU-side bus of the extended I/O unit.
//   i_ready      CPU ready; CPU-visible state only advances when high
//   i_out        CPU output register (carries the sync bit)
//   i_acc        CPU accumulator, latched into o_xout on sync
//   o_xout       extended output register (audio/LEDs)
//   o_in         input register seen on the CPU bus
//   o_sync_pulse combinational sync-edge strobe
// master = CPU core side, slave = gigatron_xio.
interface gigatron_xio_if #(
    parameter int DATA_W = 8
);
    logic              i_ready;
    logic [DATA_W-1:0] i_out;
    logic [DATA_W-1:0] i_acc;
    logic [DATA_W-1:0] o_xout;
    logic [DATA_W-1:0] o_in;
    logic              o_sync_pulse;

    modport master (
        output i_ready, i_out, i_acc,
        input  o_xout, o_in, o_sync_pulse
    );

    modport slave (
        input  i_ready, i_out, i_acc,
        output o_xout, o_in, o_sync_pulse
    );
endinterface

// File: rtl/gigatron_xio.sv
// gigatron_xio: extended I/O unit. Detects an edge on one bit of the CPU
// output register, latches the accumulator into xout, publishes the last
// controller word into the input register and runs a Famicom-style serial
// controller scan (latch / clock / data).
// Ports:
//   i_clock, i_reset_n  clock, asynchronous active-low reset
//   bus                 CPU-side interface (ready/out/acc -> xout/in/sync)
//   i_ctrl_data         serial controller data (active-low, idle high)
//   o_ctrl_latch        controller latch strobe
//   o_ctrl_clk          controller shift clock
//   o_busy              scan in progress
//   o_overrun           one-cycle pulse: sync arrived during a scan
module gigatron_xio #(
    parameter int DATA_W      = 8,
    parameter int SYNC_BIT    = 6,
    parameter int SYNC_RISING = 1,
    parameter int CTRL_BITS   = 8,
    parameter int CTRL_DIV    = 4
) (
    input  logic             i_clock,
    input  logic             i_reset_n,
    gigatron_xio_if.slave    bus,
    input  logic             i_ctrl_data,
    output logic             o_ctrl_latch,
    output logic             o_ctrl_clk,
    output logic             o_busy,
    output logic             o_overrun
);
    localparam int KW = (CTRL_BITS > 1) ? $clog2(CTRL_BITS) : 1;
    localparam int CW = (CTRL_DIV > 1) ? $clog2(CTRL_DIV) : 1;
    localparam logic [CW-1:0]     CNT_LAST = CW'(CTRL_DIV - 1);
    localparam logic [KW-1:0]     K_LAST   = KW'(CTRL_BITS - 1);
    // Low CTRL_BITS bits carry the controller word; the rest read as 1.
    localparam logic [DATA_W-1:0] LO_MASK  = {DATA_W{1'b1}} >> (DATA_W - CTRL_BITS);

    typedef enum logic [2:0] {S_IDLE, S_LATCH, S_LOW, S_HI, S_DONE} state_t;

    state_t            r_state;
    logic [CW-1:0]     r_cnt;
    logic [KW-1:0]     r_k;
    logic [DATA_W-1:0] r_shift;
    logic [DATA_W-1:0] r_shadow;
    logic [DATA_W-1:0] r_xout;
    logic [DATA_W-1:0] r_in;
    logic              r_prev;
    logic              r_pend;
    logic              r_latch;
    logic              r_clk;
    logic              r_busy;
    logic              r_overrun;

    logic              w_cur;
    logic              w_edge;
    logic              w_pulse;
    logic              w_cnt_last;
    logic [DATA_W-1:0] w_src;
    logic [DATA_W-1:0] w_pub;

    assign w_cur      = bus.i_out[SYNC_BIT];
    assign w_edge     = (SYNC_RISING != 0) ? (w_cur & ~r_prev) : (~w_cur & r_prev);
    assign w_pulse    = w_edge & bus.i_ready;
    assign w_cnt_last = (r_cnt == CNT_LAST);
    // In DONE the shadow is only being written this cycle, so bypass the
    // freshly completed shift word.
    assign w_src      = (r_state == S_DONE) ? r_shift : r_shadow;
    assign w_pub      = (w_src & LO_MASK) | ~LO_MASK;

    assign bus.o_xout       = r_xout;
    assign bus.o_in         = r_in;
    assign bus.o_sync_pulse = w_pulse;
    assign o_ctrl_latch     = r_latch;
    assign o_ctrl_clk       = r_clk;
    assign o_busy           = r_busy;
    assign o_overrun        = r_overrun;

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_k       <= '0;
            r_shift   <= '0;
            r_shadow  <= '1;
            r_xout    <= '0;
            r_in      <= '0;
            r_prev    <= 1'b0;
            r_pend    <= 1'b0;
            r_latch   <= 1'b0;
            r_clk     <= 1'b0;
            r_busy    <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_overrun <= 1'b0;
            if (bus.i_ready) r_prev <= w_cur;

            if (w_pulse) begin
                r_xout <= bus.i_acc;
                r_in   <= w_pub;
                // A sync in DONE is not an overrun: queue a restart instead.
                if (r_state == S_DONE)      r_pend    <= 1'b1;
                else if (r_state != S_IDLE) r_overrun <= 1'b1;
            end

            r_cnt <= w_cnt_last ? '0 : r_cnt + CW'(1);

            case (r_state)
                S_IDLE: begin
                    r_cnt <= '0;
                    if (w_pulse || r_pend) begin
                        r_state <= S_LATCH;
                        r_latch <= 1'b1;
                        r_busy  <= 1'b1;
                        r_pend  <= 1'b0;
                    end
                end
                S_LATCH: if (w_cnt_last) begin
                    r_state <= S_LOW;
                    r_latch <= 1'b0;
                    r_k     <= '0;
                    r_shift <= '0;
                end
                S_LOW: if (w_cnt_last) begin
                    r_shift <= (r_shift << 1) | DATA_W'(i_ctrl_data);
                    if (r_k < K_LAST) begin
                        r_state <= S_HI;
                        r_clk   <= 1'b1;
                    end else begin
                        r_state <= S_DONE;
                    end
                end
                S_HI: if (w_cnt_last) begin
                    r_state <= S_LOW;
                    r_clk   <= 1'b0;
                    r_k     <= r_k + KW'(1);
                end
                S_DONE: begin
                    r_shadow <= r_shift;
                    r_state  <= S_IDLE;
                    r_busy   <= 1'b0;
                    r_cnt    <= '0;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_gigatron_xio.sv
// Directed bench for gigatron_xio: instance A uses the default sync (bit 6,
// rising) with CTRL_DIV=2 / CTRL_BITS=8; instance B uses falling sync on
// bit 7 with CTRL_BITS=4 / CTRL_DIV=1.
module tb_gigatron_xio;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic a_data = 1'b1;
    logic b_data = 1'b1;
    logic a_latch, a_clk, a_busy, a_ovr;
    logic b_latch, b_clk, b_busy, b_ovr;
    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    gigatron_xio_if #(.DATA_W(8)) bus_a();
    gigatron_xio_if #(.DATA_W(8)) bus_b();

    gigatron_xio #(.DATA_W(8), .SYNC_BIT(6), .SYNC_RISING(1), .CTRL_BITS(8), .CTRL_DIV(2)) dut_a (
        .i_clock(clk), .i_reset_n(rst_n), .bus(bus_a), .i_ctrl_data(a_data),
        .o_ctrl_latch(a_latch), .o_ctrl_clk(a_clk), .o_busy(a_busy), .o_overrun(a_ovr));

    gigatron_xio #(.DATA_W(8), .SYNC_BIT(7), .SYNC_RISING(0), .CTRL_BITS(4), .CTRL_DIV(1)) dut_b (
        .i_clock(clk), .i_reset_n(rst_n), .bus(bus_b), .i_ctrl_data(b_data),
        .o_ctrl_latch(b_latch), .o_ctrl_clk(b_clk), .o_busy(b_busy), .o_overrun(b_ovr));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    initial begin
        logic [7:0] pat_a;
        logic [3:0] pat_b;
        int n_latch, n_hi, n_busy, n_rise, s;
        logic pclk;
        pat_a = 8'b0111_1110;
        pat_b = 4'b1010;
        bus_a.i_ready = 1'b1; bus_a.i_out = 8'h00; bus_a.i_acc = 8'h00;
        bus_b.i_ready = 1'b1; bus_b.i_out = 8'h80; bus_b.i_acc = 8'h00;

        // reset state
        repeat (3) tick;
        chk("rst_xout", bus_a.o_xout, 8'h00);
        chk("rst_in", bus_a.o_in, 8'h00);
        chk("rst_latch_clk", {a_latch, a_clk}, 2'b00);
        chk("rst_busy_ovr", {a_busy, a_ovr}, 2'b00);
        rst_n = 1'b1;
        tick;

        // rising sync, starts the patterned scan
        bus_a.i_acc = 8'h5A; bus_a.i_out = 8'h40;
        #1 chk("rise_pulse", bus_a.o_sync_pulse, 1'b1);
        tick;
        chk("rise_xout", bus_a.o_xout, 8'h5A);
        chk("rise_in_ones", bus_a.o_in, 8'hFF);
        chk("hold_no_pulse", bus_a.o_sync_pulse, 1'b0);
        n_latch = 0; n_hi = 0; n_busy = 0; n_rise = 0; pclk = 1'b0;
        for (int c = 0; c < 40; c++) begin
            if (a_latch) n_latch++;
            if (a_clk) n_hi++;
            if (a_busy) n_busy++;
            if (a_clk && !pclk) n_rise++;
            pclk = a_clk;
            if (c >= 2) a_data = pat_a[7 - ((c - 2) / 4 > 7 ? 7 : (c - 2) / 4)];
            tick;
        end
        chk("scan_latch_cyc", n_latch, 2);
        chk("scan_clkhi_cyc", n_hi, 14);
        chk("scan_clk_rises", n_rise, 7);
        chk("scan_busy_cyc", n_busy, 33);
        a_data = 1'b1;

        // next sync publishes the scanned word, starts scan 2
        bus_a.i_out = 8'h00; tick;
        bus_a.i_out = 8'h40; bus_a.i_acc = 8'hC3;
        #1 chk("sync2_pulse", bus_a.o_sync_pulse, 1'b1);
        tick;
        chk("sync2_in", bus_a.o_in, 8'h7E);
        chk("sync2_xout", bus_a.o_xout, 8'hC3);
        chk("sync2_busy", a_busy, 1'b1);
        bus_a.i_out = 8'h00;
        repeat (9) tick;
        // overrun: sync 10 cycles after the previous one
        bus_a.i_out = 8'h40; bus_a.i_acc = 8'h11;
        #1 chk("ovr_pulse", bus_a.o_sync_pulse, 1'b1);
        tick;
        chk("ovr_flag", a_ovr, 1'b1);
        chk("ovr_xout", bus_a.o_xout, 8'h11);
        chk("ovr_in", bus_a.o_in, 8'h7E);
        tick;
        chk("ovr_one_cycle", a_ovr, 1'b0);
        s = 11;
        while (a_busy && s < 80) begin tick; s++; end
        chk("ovr_no_restart_len", s, 33);
        repeat (3) tick;
        chk("ovr_stays_idle", a_busy, 1'b0);

        // ready stall
        bus_a.i_out = 8'h00; tick;
        bus_a.i_ready = 1'b0; bus_a.i_out = 8'h40; bus_a.i_acc = 8'h99;
        #1 chk("stall_no_pulse", bus_a.o_sync_pulse, 1'b0);
        tick;
        chk("stall_xout_hold", bus_a.o_xout, 8'h11);
        tick;
        bus_a.i_ready = 1'b1;
        #1 chk("stall_release_pulse", bus_a.o_sync_pulse, 1'b1);
        tick;
        chk("stall_xout", bus_a.o_xout, 8'h99);
        chk("stall_in", bus_a.o_in, 8'hFF);

        // reset mid-scan (in a clk-high phase)
        repeat (4) tick;
        chk("mid_clk_high", a_clk, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_latch_clk", {a_latch, a_clk}, 2'b00);
        chk("mid_rst_busy", a_busy, 1'b0);
        chk("mid_rst_xout", bus_a.o_xout, 8'h00);
        chk("mid_rst_in", bus_a.o_in, 8'h00);
        tick; tick;
        bus_a.i_acc = 8'h24;
        rst_n = 1'b1;
        #1 chk("post_rst_pulse", bus_a.o_sync_pulse, 1'b1);
        tick;
        chk("post_rst_in", bus_a.o_in, 8'hFF);
        chk("post_rst_xout", bus_a.o_xout, 8'h24);

        // falling-mode instance, DONE-cycle bypass
        tick;
        bus_b.i_acc = 8'h3C; bus_b.i_out = 8'h00;
        #1 chk("b_fall_pulse", bus_b.o_sync_pulse, 1'b1);
        tick;
        chk("b_xout", bus_b.o_xout, 8'h3C);
        chk("b_in_ones", bus_b.o_in, 8'hFF);
        chk("b_busy", b_busy, 1'b1);
        for (int c = 0; c < 8; c++) begin
            if (c >= 1) b_data = pat_b[3 - (c - 1) / 2];
            if (c == 6) begin
                bus_b.i_out = 8'h80;
                #1 chk("b_rise_ignored", bus_b.o_sync_pulse, 1'b0);
            end
            tick;
        end
        bus_b.i_out = 8'h00; bus_b.i_acc = 8'h77;
        #1 chk("b_done_pulse", bus_b.o_sync_pulse, 1'b1);
        chk("b_done_busy", b_busy, 1'b1);
        tick;
        chk("b_bypass_in", bus_b.o_in, 8'hFA);
        chk("b_bypass_xout", bus_b.o_xout, 8'h77);
        chk("b_no_overrun", b_ovr, 1'b0);
        chk("b_idle_gap", b_busy, 1'b0);
        tick;
        chk("b_restart", {b_busy, b_latch}, 2'b11);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
